// File: rtl/tpr_keyboard_pkg.sv
// tpr_keyboard_pkg: key-state encoding and default debounce depth shared by the keyboard front end
package tpr_keyboard_pkg;
  localparam logic [1:0] KEY_RELEASED   = 2'b00;
  localparam logic [1:0] KEY_PRESS_PEND = 2'b01;
  localparam logic [1:0] KEY_HELD       = 2'b10;
  localparam logic [1:0] KEY_REL_PEND   = 2'b11;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
endpackage

// File: rtl/tpr_key_debounce.sv
// tpr_key_debounce: two-flop synchroniser, saturating counter and press/release FSM for one key contact
module tpr_key_debounce
  import tpr_keyboard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic d,
  output logic press
);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(DEBOUNCE_CYCLES);
  logic [1:0] sync, state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic s;
  assign s = sync[1];
  assign cnt_inc = (cnt >= MAXC) ? MAXC : cnt + 1'b1;
  // d is the debounced level the key holds after this edge, so the top registers it with no extra stage
  assign d = state_nxt[1];
  // next state: a pending phase survives only while the synchronised sample agrees with it
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    press = 1'b0;
    case (state)
      KEY_RELEASED: begin
        state_nxt = s ? KEY_PRESS_PEND : KEY_RELEASED;
        cnt_nxt = s ? CNT_W'(1) : '0;
      end
      KEY_PRESS_PEND:
        if (!s) state_nxt = KEY_RELEASED;
        else if (cnt_inc == MAXC) begin
          state_nxt = KEY_HELD;
          press = 1'b1;
        end else cnt_nxt = cnt_inc;
      KEY_HELD: begin
        state_nxt = s ? KEY_HELD : KEY_REL_PEND;
        cnt_nxt = s ? '0 : CNT_W'(1);
      end
      default:
        if (s) state_nxt = KEY_HELD;
        else if (cnt_inc == MAXC) state_nxt = KEY_RELEASED;
        else cnt_nxt = cnt_inc;
    endcase
  end
  // synchroniser, FSM state and counter, all cleared at once by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      state <= KEY_RELEASED;
      cnt <= '0;
    end else begin
      sync <= {sync[0], raw};
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
endmodule

// File: rtl/tpr_keyboard.sv
// tpr_keyboard: debounced TPR key row with a half-action-frozen output word, activity and press-event flags
module tpr_keyboard
  import tpr_keyboard_pkg::*;
#(
  parameter int LINE_LENGTH = 40,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = 5
) (
  input  logic w_CLK,
  input  logic w_RST,
  input  logic [0:LINE_LENGTH-1] b_KEY_RAW,
  input  logic w_HA,
  output logic [0:LINE_LENGTH-1] b_TPR_DATA_OUT,
  output logic w_KEY_ACTIVE,
  output logic w_KEY_EVENT
);
  logic [0:LINE_LENGTH-1] d, press;
  for (genvar i = 0; i < LINE_LENGTH; i++) begin : g_key
    tpr_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key (
      .clk(w_CLK),
      .rst(w_RST),
      .raw(b_KEY_RAW[i]),
      .d(d[i]),
      .press(press[i])
    );
  end
  // store word follows the keys except across a half-action beat; flags are never frozen
  always_ff @(posedge w_CLK or posedge w_RST)
    if (w_RST) begin
      b_TPR_DATA_OUT <= '0;
      w_KEY_ACTIVE <= 1'b0;
      w_KEY_EVENT <= 1'b0;
    end else begin
      b_TPR_DATA_OUT <= w_HA ? b_TPR_DATA_OUT : d;
      w_KEY_ACTIVE <= |d;
      w_KEY_EVENT <= |press;
    end
endmodule

// File: tb/tb_tpr_keyboard.sv
// tb_tpr_keyboard: scoreboard bench with a run-length debounce reference model, directed and random stimulus
module tb_tpr_keyboard;
  localparam int L = 40;
  localparam int DB = 16;
  logic clk = 0, rst = 0, ha = 0;
  logic [0:L-1] raw = '0, out;
  logic act, ev;
  tpr_keyboard #(.LINE_LENGTH(L), .DEBOUNCE_CYCLES(DB), .CNT_W(5)) dut (
    .w_CLK(clk),
    .w_RST(rst),
    .b_KEY_RAW(raw),
    .w_HA(ha),
    .b_TPR_DATA_OUT(out),
    .w_KEY_ACTIVE(act),
    .w_KEY_EVENT(ev)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [0:L-1] o;
    logic a;
    logic e;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, ev_seen = 0;
  logic [0:L-1] m_p1 = '0, m_p2 = '0, m_out = '0, dst = '0;
  int run[L];
  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (ev === 1'b1) ev_seen++;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("out", out, x.o);
      chk("active", act, x.a);
      chk("event", ev, x.e);
    end
  end
  task automatic model_reset();
    m_p1 = '0;
    m_p2 = '0;
    m_out = '0;
    dst = '0;
    for (int i = 0; i < L; i++) run[i] = 0;
  endtask
  task automatic step(input logic [0:L-1] r, input logic h);
    exp_t x;
    logic e;
    @(negedge clk);
    raw = r;
    ha = h;
    @(posedge clk);
    e = 1'b0;
    for (int i = 0; i < L; i++) begin
      run[i] = (m_p2[i] != dst[i]) ? run[i] + 1 : 0;
      if (run[i] == DB) begin
        dst[i] = m_p2[i];
        run[i] = 0;
        if (m_p2[i]) e = 1'b1;
      end
    end
    m_p2 = m_p1;
    m_p1 = r;
    if (!h) m_out = dst;
    x.o = m_out;
    x.a = |dst;
    x.e = e;
    q.push_back(x);
  endtask
  task automatic hold(input logic [0:L-1] r, input logic h, input int n);
    repeat (n) step(r, h);
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out", out, '0);
    chk("rst_active", act, 0);
    chk("rst_event", ev, 0);
    q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask
  initial begin
    logic [0:L-1] r;
    logic h;
    int e0;
    bit dropped;
    model_reset();
    do_reset();
    r = '0;
    r[3] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step(r, 0);
      #1;
      if (k == 17) chk("t1_before", out[3], 0);
      if (k == 18) begin
        chk("t1_out", out[3], 1);
        chk("t1_active", act, 1);
        chk("t1_event", ev, 1);
      end
    end
    step(r, 0);
    #1 chk("t1_event_once", ev, 0);
    e0 = ev_seen;
    for (int b = 0; b < 4; b++) begin
      r[7] = (b % 2 == 0);
      hold(r, 0, 3);
      #1 chk("t2_bounce", out[7], 0);
    end
    r[7] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step(r, 0);
      #1;
      if (k == 17) chk("t2_before", out[7], 0);
      if (k == 18) chk("t2_out", out[7], 1);
    end
    hold(r, 0, 2);
    chk("t2_events", ev_seen - e0, 1);
    r[0] = 1'b1;
    hold(r, 1, 20);
    #1;
    chk("t3_frozen", out[0], 0);
    chk("t3_active", act, 1);
    step(r, 0);
    #1 chk("t3_release", out[0], 1);
    hold('0, 0, 20);
    e0 = ev_seen;
    r = '0;
    r[0] = 1'b1;
    r[19] = 1'b1;
    r[39] = 1'b1;
    hold(r, 0, 20);
    #1 chk("t4_bits", {out[0], out[19], out[39]}, 3'b111);
    chk("t4_events", ev_seen - e0, 1);
    e0 = ev_seen;
    dropped = 0;
    r[0] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k == 10) r[0] = 1'b1;
      step(r, 0);
      #1 if (out[0] !== 1'b1) dropped = 1;
    end
    chk("t5_dropped", dropped, 0);
    chk("t5_events", ev_seen - e0, 0);
    do_reset();
    hold(r, 0, 8);
    do_reset();
    hold(r, 0, 17);
    #1 chk("t6_before", out[19], 0);
    step(r, 0);
    #1 chk("t6_out", out[19], 1);
    h = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < L; i++) if ($urandom_range(47) == 0) r[i] = ~r[i];
      if ($urandom_range(9) == 0) h = ~h;
      if ($urandom_range(599) == 0) do_reset();
      step(r, h);
    end
    hold('0, 0, 40);
    @(negedge clk);
    #1 chk("drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
